ov7670_reg_sequencer: RTL and testbench
=======================================

OV7670_REG_SEQUENCER -- requirements
Module: ov7670_reg_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 25000, SHALL set the ov7670_reset assertion length in clk cycles (1 ms at 25 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 25000, SHALL set the wait after reset release before the first register write.
REQ-003 Parameter MAX_RETRY, default 3, SHALL set the number of re-attempts per register after a NACK.
REQ-004 clk  input  1  core clock (25 MHz); all logic in this single domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 restart  input  1  single-cycle pulse; restarts the full sequence from any state.
REQ-007 sccb_req  output  1  write request to the SCCB master.
REQ-008 sccb_addr  output  8  camera register address.
REQ-009 sccb_data  output  8  camera register data.
REQ-010 sccb_done  input  1  single-cycle pulse; the current transaction has finished.
REQ-011 sccb_nack  input  1  valid with sccb_done; the camera did not acknowledge.
REQ-012 ov7670_reset  output  1  active-low camera reset.
REQ-013 ov7670_pwrdn  output  1  camera power-down; held 0 outside reset.
REQ-014 start_capture  output  1  level; 1 once all registers are written.
REQ-015 error  output  1  level; 1 once a register exhausts its retries.

Function
REQ-016 The FSM SHALL have the states RST_PULSE, SETTLE, ISSUE, WAIT, NEXT, DONE and FAIL.
REQ-017 RST_PULSE SHALL drive ov7670_reset=0 for exactly RESET_CYCLES cycles, then go to SETTLE.
REQ-018 SETTLE SHALL hold ov7670_reset=1 for SETTLE_CYCLES cycles, then go to ISSUE with index 0.
REQ-019 In ISSUE, sccb_req SHALL rise the cycle after entry, with sccb_addr/sccb_data taken from table[index], and the FSM SHALL move to WAIT.
REQ-020 sccb_req, sccb_addr and sccb_data SHALL stay stable until sccb_done; sccb_req SHALL fall in the cycle after sccb_done.
REQ-021 On sccb_done with sccb_nack=0, the FSM SHALL go to NEXT and clear the retry count.
REQ-022 On sccb_done with sccb_nack=1 and retry<MAX_RETRY, the FSM SHALL increment retry and re-enter ISSUE with the same index.
REQ-023 On sccb_done with sccb_nack=1 and retry=MAX_RETRY, the FSM SHALL enter FAIL with error=1 and start_capture=0.
REQ-024 NEXT SHALL wait 1 cycle, increment the index, then go to ISSUE, or to DONE if index was NUM_REGS-1.
REQ-025 DONE SHALL set start_capture=1; DONE and FAIL SHALL hold until reset or restart.
REQ-026 restart SHALL go to RST_PULSE, clear start_capture, error, index and retry, and drop sccb_req, even mid-transaction.
REQ-027 An sccb_done pulse outside WAIT SHALL be ignored.
REQ-028 Simultaneous restart and sccb_done: restart SHALL take priority.
REQ-029 The delay counter SHALL be wide enough for max(RESET_CYCLES, SETTLE_CYCLES) and SHALL NOT wrap.

Reset
REQ-030 While reset=1, the outputs SHALL be: sccb_req=0, sccb_addr=0, sccb_data=0, ov7670_reset=0, ov7670_pwrdn=0, start_capture=0, error=0, state=RST_PULSE, all counters 0.
REQ-031 After reset deasserts, the sequence SHALL start automatically from RST_PULSE.

Configuration
REQ-032 With OV7670_TEST_PATTERN_EN defined, the table SHALL append two entries, 0x70<-0x3A and 0x71<-0xB5 (8-bar colour bars), making NUM_REGS=BASE_REGS+2.
REQ-033 Without OV7670_TEST_PATTERN_EN, NUM_REGS=BASE_REGS and these entries SHALL be absent.

Structure
REQ-034 Package ov7670_pkg SHALL hold BASE_REGS, NUM_REGS, the 16-bit {addr,data} entry type, the FSM state encoding and the register address constants.
REQ-035 The table SHALL be a combinational sub-module ov7670_reg_rom (index in, {addr,data} out); the first base entry SHALL be 0x12<-0x80 (COM7 soft reset), followed by a 10-cycle extra NEXT delay.

Verification
REQ-036 Reset release, RESET_CYCLES=10, SETTLE_CYCLES=20 -> ov7670_reset low cycles 0-9, first sccb_req at cycle 31 with addr 0x12, data 0x80.
REQ-037 An SCCB model that ACKs every write after 5 cycles -> exactly NUM_REGS transactions in table order, then start_capture=1, error=0.
REQ-038 NACK twice on index 3, then ACK -> index 3 issued 3 times, sequence completes, start_capture=1.
REQ-039 NACK always on index 2, MAX_RETRY=3 -> 4 attempts, then error=1, sccb_req=0, start_capture stays 0.
REQ-040 restart pulse during WAIT on index 5 -> next cycle sccb_req=0 and ov7670_reset=0; the sequence replays from index 0.
REQ-041 Build with and without OV7670_TEST_PATTERN_EN -> last two writes 0x70/0x3A and 0x71/0xB5 present or absent; transaction count differs by 2.

Source files
------------

// File: rtl/ov7670_reg_sequencer_pkg.sv
// ov7670_pkg -- shared types and constants for the OV7670 register sequencer.
//   BASE_REGS / NUM_REGS : size of the init table (NUM_REGS grows by 2 when
//                          OV7670_TEST_PATTERN_EN is defined, adding colour bars)
//   reg_entry_t          : one 16-bit {addr,data} table entry
//   state_t              : sequencer FSM encoding
//   REG_*                : OV7670 register addresses used by the table
// Macro: OV7670_TEST_PATTERN_EN (optional test-pattern entries).
package ov7670_pkg;

  localparam int BASE_REGS = 10;
`ifdef OV7670_TEST_PATTERN_EN
  localparam int NUM_REGS  = BASE_REGS + 2;
`else
  localparam int NUM_REGS  = BASE_REGS;
`endif
  localparam int IDX_W     = $clog2(NUM_REGS);

  // COM7 soft reset needs time before the next write lands.
  localparam int COM7_RST_DLY = 10;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_entry_t;

  typedef enum logic [2:0] {
    RST_PULSE,
    SETTLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    FAIL
  } state_t;

  localparam logic [7:0] REG_COM1        = 8'h04;
  localparam logic [7:0] REG_COM3        = 8'h0C;
  localparam logic [7:0] REG_CLKRC       = 8'h11;
  localparam logic [7:0] REG_COM7        = 8'h12;
  localparam logic [7:0] REG_COM8        = 8'h13;
  localparam logic [7:0] REG_TSLB        = 8'h3A;
  localparam logic [7:0] REG_COM14       = 8'h3E;
  localparam logic [7:0] REG_COM15       = 8'h40;
  localparam logic [7:0] REG_SCALING_XSC = 8'h70;
  localparam logic [7:0] REG_SCALING_YSC = 8'h71;
  localparam logic [7:0] REG_RGB444      = 8'h8C;

endpackage

// File: rtl/ov7670_reg_sequencer_if.sv
// ov7670_reg_sequencer_if -- write-request bus between the sequencer and an
// SCCB master.
//   sccb_req/addr/data : write request, held stable until sccb_done
//   sccb_done          : one-cycle completion pulse from the SCCB master
//   sccb_nack          : valid with sccb_done, camera did not acknowledge
// Modports: master (sequencer side), slave (SCCB master side).
interface ov7670_reg_sequencer_if;
  logic       sccb_req;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (output sccb_req, sccb_addr, sccb_data,
                  input  sccb_done, sccb_nack);
  modport slave  (input  sccb_req, sccb_addr, sccb_data,
                  output sccb_done, sccb_nack);
endinterface

// File: rtl/ov7670_reg_sequencer_rom.sv
// ov7670_reg_rom -- combinational init table, index in, {addr,data} out.
//   idx_i   : table index (0..NUM_REGS-1)
//   entry_o : register address/data at that index (0 when out of range)
// Macro: OV7670_TEST_PATTERN_EN appends the 8-bar colour-bar entries.
module ov7670_reg_rom
  import ov7670_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output reg_entry_t       entry_o
);

  always_comb begin
    entry_o = '0;
    case (int'(idx_i))
      0:  entry_o = '{REG_COM7,   8'h80};  // soft reset, all regs to default
      1:  entry_o = '{REG_COM7,   8'h04};  // RGB output
      2:  entry_o = '{REG_CLKRC,  8'h01};
      3:  entry_o = '{REG_COM3,   8'h00};
      4:  entry_o = '{REG_COM14,  8'h00};
      5:  entry_o = '{REG_COM15,  8'hD0};  // RGB565, full range
      6:  entry_o = '{REG_RGB444, 8'h00};
      7:  entry_o = '{REG_COM1,   8'h00};
      8:  entry_o = '{REG_TSLB,   8'h04};
      9:  entry_o = '{REG_COM8,   8'hE7};
`ifdef OV7670_TEST_PATTERN_EN
      10: entry_o = '{REG_SCALING_XSC, 8'h3A};
      11: entry_o = '{REG_SCALING_YSC, 8'hB5};
`endif
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/ov7670_reg_sequencer.sv
// ov7670_reg_sequencer -- powers up an OV7670: pulses its reset, waits for it
// to settle, then writes the init table over SCCB with per-register retries.
//   clk, reset    : core clock, async active-high reset
//   restart       : one-cycle pulse, replays the whole sequence from any state
//   sccb          : write-request bus (master modport)
//   ov7670_reset  : active-low camera reset
//   ov7670_pwrdn  : camera power-down, always 0
//   start_capture : level, all registers written
//   error         : level, a register exhausted its retries
// Parameters: RESET_CYCLES, SETTLE_CYCLES, MAX_RETRY.
// Macro: OV7670_TEST_PATTERN_EN (table length, see ov7670_pkg).
module ov7670_reg_sequencer
  import ov7670_pkg::*;
#(
  parameter int RESET_CYCLES  = 25000,
  parameter int SETTLE_CYCLES = 25000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  ov7670_reg_sequencer_if.master        sccb,
  output logic                          ov7670_reset,
  output logic                          ov7670_pwrdn,
  output logic                          start_capture,
  output logic                          error
);

  localparam int CNT_MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > COM7_RST_DLY + 1) ? CNT_MAX_A : COM7_RST_DLY + 1;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               req_q, req_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [CNT_W-1:0]   next_last;
  reg_entry_t         rom_entry;

  ov7670_reg_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  // After the COM7 soft reset the camera needs extra idle time.
  assign next_last = (idx_q == '0) ? CNT_W'(COM7_RST_DLY) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_PULSE;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // Saturating count: it is only meaningful in delay states and never wraps.
    cnt_d   = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    retry_d = retry_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (restart) begin
      // Wins over everything, including a coincident sccb_done.
      state_d = RST_PULSE;
      cnt_d   = '0;
      idx_d   = '0;
      retry_d = '0;
      req_d   = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end else begin
      unique case (state_q)
        RST_PULSE: if (cnt_q == RST_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: if (cnt_q == SET_LAST) begin
          state_d = ISSUE;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ISSUE: begin
          req_d   = 1'b1;
          addr_d  = rom_entry.addr;
          data_d  = rom_entry.data;
          state_d = WAIT;
        end
        WAIT: if (sccb.sccb_done) begin
          req_d = 1'b0;
          if (!sccb.sccb_nack) begin
            state_d = NEXT;
            retry_d = '0;
            cnt_d   = '0;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = ISSUE;
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            state_d = FAIL;
          end
        end
        NEXT: if (cnt_q == next_last) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
        DONE, FAIL: ;
        default: state_d = RST_PULSE;
      endcase
    end
  end

  assign sccb.sccb_req  = req_q;
  assign sccb.sccb_addr = addr_q;
  assign sccb.sccb_data = data_q;
  assign ov7670_reset   = (state_q != RST_PULSE);
  assign ov7670_pwrdn   = 1'b0;
  assign start_capture  = (state_q == DONE);
  assign error          = (state_q == FAIL);

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// Scoreboard bench for ov7670_reg_sequencer: a responder models the SCCB
// master (done 5 cycles after each request, NACKs per scenario policy), the
// main process queues the expected write sequence, and a monitor pops and
// compares on every new request.
module tb_ov7670_reg_sequencer;

  localparam int RC = 10;
  localparam int SC = 20;
  localparam int MR = 3;
`ifdef OV7670_TEST_PATTERN_EN
  localparam int NREG = 12;
  localparam logic [15:0] LAST_AD = 16'h71B5;
  localparam logic [15:0] PREV_AD = 16'h703A;
`else
  localparam int NREG = 10;
  localparam logic [15:0] LAST_AD = 16'h13E7;
  localparam logic [15:0] PREV_AD = 16'h3A04;
`endif

  logic clk = 1'b0;
  logic reset, restart;
  logic ov_rst, ov_pd, start_cap, err;

  ov7670_reg_sequencer_if sif ();

  ov7670_reg_sequencer #(
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .sccb          (sif),
    .ov7670_reset  (ov_rst),
    .ov7670_pwrdn  (ov_pd),
    .start_capture (start_cap),
    .error         (err)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] expq[$];
  int tx_cnt = 0;
  logic [15:0] last_ad = '0, prev_last_ad = '0;
  int pos = 0, nk = 0, att = 0;
  int nack_pos = -1, nack_lim = 0;

  function automatic logic [15:0] exp_entry(input int i);
    case (i)
      0:  return 16'h1280;
      1:  return 16'h1204;
      2:  return 16'h1101;
      3:  return 16'h0C00;
      4:  return 16'h3E00;
      5:  return 16'h40D0;
      6:  return 16'h8C00;
      7:  return 16'h0400;
      8:  return 16'h3A04;
      9:  return 16'h13E7;
      10: return 16'h703A;
      11: return 16'h71B5;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic push_full();
    for (int i = 0; i < NREG; i++) expq.push_back(exp_entry(i));
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int lim);
    int n;
    n = 0;
    while (!(start_cap || err) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < lim), 32'd1);
  endtask

  // Monitor: one scoreboard pop per rising sccb_req, stability while high.
  initial begin : monitor
    logic prev_req;
    logic [15:0] prev_v, cur;
    prev_req = 1'b0;
    prev_v   = '0;
    forever begin
      @(negedge clk);
      cur = {sif.sccb_addr, sif.sccb_data};
      if (!reset) begin
        if (sif.sccb_req && !prev_req) begin
          tx_cnt++;
          prev_last_ad = last_ad;
          last_ad      = cur;
          if (expq.size() == 0) chk("tx_extra", 32'(expq.size()), 32'd1);
          else                  chk("tx_entry", 32'(cur), 32'(expq.pop_front()));
        end else if (sif.sccb_req && prev_req) begin
          chk("req_stable", 32'(cur), 32'(prev_v));
        end
      end
      prev_req = sif.sccb_req;
      prev_v   = cur;
    end
  end

  // SCCB model: done 5 cycles after the request is seen, NACK per policy.
  initial begin : responder
    bit abort, nk_now;
    sif.sccb_done = 1'b0;
    sif.sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (restart) begin
        pos = 0; nk = 0; att = 0;
      end else if (sif.sccb_req && !reset) begin
        abort = 1'b0;
        if (pos == nack_pos) att++;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (restart) begin
            abort = 1'b1; pos = 0; nk = 0; att = 0;
          end
        end
        // A done after restart is stale: the DUT must ignore it.
        nk_now = !abort && (pos == nack_pos) && (nk < nack_lim);
        sif.sccb_done = 1'b1;
        sif.sccb_nack = nk_now;
        if (nk_now) nk++;
        else if (!abort) pos++;
        @(negedge clk);
        sif.sccb_done = 1'b0;
        sif.sccb_nack = 1'b0;
      end
    end
  end

  initial begin : main
    int low_cnt, last_low, first_hi, first_req, base;
    reset = 1'b1;
    restart = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(sif.sccb_req),  32'd0);
    chk("rst_addr",  32'(sif.sccb_addr), 32'd0);
    chk("rst_data",  32'(sif.sccb_data), 32'd0);
    chk("rst_ovrst", 32'(ov_rst),        32'd0);
    chk("rst_pwrdn", 32'(ov_pd),         32'd0);
    chk("rst_start", 32'(start_cap),     32'd0);
    chk("rst_err",   32'(err),           32'd0);

    // Power-up timing and a clean ACK run
    push_full();
    base = tx_cnt;
    @(posedge clk); #1 reset = 1'b0;
    low_cnt = 0; last_low = -1; first_hi = -1; first_req = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!ov_rst) begin low_cnt++; last_low = k; end
      else if (first_hi < 0) first_hi = k;
      if (sif.sccb_req && first_req < 0) begin
        first_req = k;
        break;
      end
    end
    chk("ovrst_low_cycles", 32'(low_cnt),   32'd10);
    chk("ovrst_last_low",   32'(last_low),  32'd9);
    chk("ovrst_first_high", 32'(first_hi),  32'd10);
    chk("first_req_cycle",  32'(first_req), 32'd31);
    chk("first_addr",       32'(sif.sccb_addr), 32'h12);
    chk("first_data",       32'(sif.sccb_data), 32'h80);
    wait_end("ack_run_timeout", 2000);
    chk("ack_start", 32'(start_cap), 32'd1);
    chk("ack_err",   32'(err),       32'd0);
    chk("ack_count", 32'(tx_cnt - base), 32'(NREG));
    chk("ack_qleft", 32'(expq.size()),   32'd0);
    chk("ack_req",   32'(sif.sccb_req),  32'd0);
    chk("ack_pwrdn", 32'(ov_pd),         32'd0);
    chk("last_write",      32'(last_ad),      32'(LAST_AD));
    chk("prev_last_write", 32'(prev_last_ad), 32'(PREV_AD));

    // Two NACKs on index 3 then ACK
    nack_pos = 3; nack_lim = 2;
    pulse_restart();
    chk("rs_start_clr", 32'(start_cap), 32'd0);
    base = tx_cnt;
    for (int i = 0; i <= 3; i++) expq.push_back(exp_entry(i));
    expq.push_back(exp_entry(3));
    expq.push_back(exp_entry(3));
    for (int i = 4; i < NREG; i++) expq.push_back(exp_entry(i));
    wait_end("retry_run_timeout", 2000);
    chk("retry_start", 32'(start_cap),      32'd1);
    chk("retry_err",   32'(err),            32'd0);
    chk("retry_count", 32'(tx_cnt - base),  32'(NREG + 2));
    chk("retry_att3",  32'(att),            32'd3);
    chk("retry_qleft", 32'(expq.size()),    32'd0);

    // Permanent NACK on index 2: 1 + MAX_RETRY attempts, then error
    nack_pos = 2; nack_lim = 100;
    pulse_restart();
    base = tx_cnt;
    for (int i = 0; i <= 2; i++) expq.push_back(exp_entry(i));
    repeat (3) expq.push_back(exp_entry(2));
    wait_end("fail_run_timeout", 2000);
    chk("fail_err",   32'(err),           32'd1);
    chk("fail_start", 32'(start_cap),     32'd0);
    chk("fail_req",   32'(sif.sccb_req),  32'd0);
    chk("fail_att2",  32'(att),           32'd4);
    chk("fail_count", 32'(tx_cnt - base), 32'd6);
    chk("fail_qleft", 32'(expq.size()),   32'd0);
    repeat (20) @(negedge clk);
    chk("fail_hold_err",   32'(err),       32'd1);
    chk("fail_hold_start", 32'(start_cap), 32'd0);

    // Restart while waiting on index 5, then full replay
    nack_pos = -1; nack_lim = 0;
    pulse_restart();
    chk("rs_err_clr", 32'(err), 32'd0);
    base = tx_cnt;
    push_full();
    begin : wait_idx5
      int n;
      n = 0;
      while ((tx_cnt - base) < 6 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("idx5_reached", 32'(n < 1000), 32'd1);
    end
    pulse_restart();
    @(negedge clk);
    chk("mid_rs_req",   32'(sif.sccb_req), 32'd0);
    chk("mid_rs_ovrst", 32'(ov_rst),       32'd0);
    expq.delete();
    push_full();
    base = tx_cnt;
    wait_end("replay_timeout", 2000);
    chk("replay_start", 32'(start_cap),     32'd1);
    chk("replay_err",   32'(err),           32'd0);
    chk("replay_count", 32'(tx_cnt - base), 32'(NREG));
    chk("replay_qleft", 32'(expq.size()),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
